// File: rtl/filter_waveform_capture.sv
// Captures one WAVE_LEN-sample waveform of the IIR integrator output per start pulse into a RAM,
// then drains it in index order over a valid/ready stream flagged with an end-of-waveform marker.
module filter_waveform_capture #(
  parameter int DATA_W   = 16,
  parameter int WAVE_LEN = 1024,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic [CNT_W-1:0]  wave_count,
  output logic [CNT_W-1:0]  missed_starts
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WAVE_LEN - 1);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_done;

  logic [DATA_W-1:0] rd_data;
  logic              rd_pending;
  logic              rd_pending_last;

  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;
  logic              skid_last;

  logic              pop;
  logic              final_xfer;
  logic              wr_en;
  logic              rd_en;
  logic              start_missed;
  logic [1:0]        occ_after;

  // A read is only issued when its data is guaranteed a slot (output or skid) one edge later,
  // counting the read already in flight and the transfer happening on this edge.
  always_comb begin
    pop          = dout_valid && dout_ready;
    final_xfer   = pop && dout_last;
    wr_en        = (state == CAPTURE) && din_valid && !abort;
    occ_after    = 2'(dout_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(pop);
    rd_en        = (state == READOUT) && !abort && !rd_done && (occ_after < 2'd2);
    start_missed = start && (state != IDLE) && !abort;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rd_done         <= 1'b0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      skid_data       <= '0;
      skid_valid      <= 1'b0;
      skid_last       <= 1'b0;
      dout            <= '0;
      dout_valid      <= 1'b0;
      dout_last       <= 1'b0;
      wave_count      <= '0;
      missed_starts   <= '0;
    end else begin
      if (start_missed && (missed_starts != '1)) begin
        missed_starts <= missed_starts + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= CAPTURE;
            busy   <= 1'b1;
            wr_ptr <= '0;
          end
        end

        CAPTURE: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else if (din_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_IDX) begin
              state      <= READOUT;
              rd_ptr     <= '0;
              rd_done    <= 1'b0;
              rd_pending <= 1'b0;
              skid_valid <= 1'b0;
            end
          end
        end

        READOUT: begin
          if (abort || final_xfer) begin
            state      <= IDLE;
            busy       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_done    <= 1'b0;
            rd_pending <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (!abort) begin
              wave_count <= wave_count + 1'b1;
            end
          end else begin
            rd_pending <= rd_en;
            if (rd_en) begin
              rd_pending_last <= (rd_ptr == LAST_IDX);
              rd_ptr          <= rd_ptr + 1'b1;
              if (rd_ptr == LAST_IDX) begin
                rd_done <= 1'b1;
              end
            end

            // Output stage refills from the skid entry first so that order is preserved.
            if (pop || !dout_valid) begin
              if (skid_valid) begin
                dout       <= skid_data;
                dout_last  <= skid_last;
                dout_valid <= 1'b1;
                skid_valid <= rd_pending;
                if (rd_pending) begin
                  skid_data <= rd_data;
                  skid_last <= rd_pending_last;
                end
              end else if (rd_pending) begin
                dout       <= rd_data;
                dout_last  <= rd_pending_last;
                dout_valid <= 1'b1;
              end else begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
              end
            end else if (rd_pending) begin
              skid_data  <= rd_data;
              skid_last  <= rd_pending_last;
              skid_valid <= 1'b1;
            end
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          skid_valid <= 1'b0;
          rd_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
